// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default reset PC, NOP
// encoding and the queue entry layout (instruction word above its PC).
package fetch_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] DEFAULT_NOP_INST = 32'h3400_0000;
  localparam logic [PC_W-1:0]   DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush and occupancy count; only the
// pointers and count are reset, the storage array is not.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem[wr_q] <= wdata_i;
  end

  assign head_o  = mem[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC sequencer issuing one ROM read per cycle under
// credit, with returned words queued for decode and redirect flushing.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                     PC_WIDTH       = 32,
  parameter int                     INST_WIDTH     = 32,
  parameter int                     ROM_ADDR_WIDTH = 10,
  parameter int                     DEPTH          = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_PC       = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter logic [INST_WIDTH-1:0]  NOP_INST       = INST_WIDTH'(DEFAULT_NOP_INST)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_in,
  input  logic [PC_WIDTH-1:0]       redirect_pc_in,
  input  logic                      stall_in,
  output logic [ROM_ADDR_WIDTH-1:0] imem_addr_out,
  output logic                      imem_req_out,
  input  logic [INST_WIDTH-1:0]     imem_data_in,
  output logic [INST_WIDTH-1:0]     instruction_out,
  output logic [PC_WIDTH-1:0]       pc_out,
  output logic [PC_WIDTH-1:0]       pc_seq_out,
  output logic                      valid_out,
  output logic [$clog2(DEPTH):0]    count_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_WIDTH-1:0]            fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]            inflight_pc_q, inflight_pc_d;
  logic                           inflight_q, inflight_d;
  logic [CW-1:0]                  count;
  logic [CW:0]                    used;
  logic                           issue, push, pop;
  logic [INST_WIDTH+PC_WIDTH-1:0] head;
  logic [INST_WIDTH-1:0]          head_inst;
  logic [PC_WIDTH-1:0]            head_pc;

  // An in-flight read already owns a queue slot, so the push it produces
  // can never find the queue full.
  assign used  = {1'b0, count} + {{(CW){1'b0}}, inflight_q};
  assign issue = reset && !redirect_in && (used < (CW+1)'(DEPTH));
  assign push  = inflight_q && !redirect_in;
  assign pop   = valid_out && !stall_in;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect_in) begin
      fetch_pc_d = redirect_pc_in & ~PC_WIDTH'(3);
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + PC_WIDTH'(4);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_WIDTH + PC_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redirect_in),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({imem_data_in, inflight_pc_q}),
    .head_o  (head),
    .count_o (count)
  );

  assign {head_inst, head_pc} = head;

  // The redirect cycle hides the head so decode never consumes a stale word.
  assign valid_out       = (count != '0) && !redirect_in;
  assign instruction_out = valid_out ? head_inst : NOP_INST;
  assign pc_out          = valid_out ? head_pc : '0;
  assign pc_seq_out      = pc_out + PC_WIDTH'(4);
  assign count_out       = count;
  assign imem_req_out    = issue;
  assign imem_addr_out   = fetch_pc_q[ROM_ADDR_WIDTH+1:2];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random stall/redirect traffic,
// each cycle compared against a queue-based model of the fetch pipeline.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h3400_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        stall_in;
  logic [9:0]  imem_addr_out;
  logic        imem_req_out;
  logic [31:0] imem_data_in;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] pc_seq_out;
  logic        valid_out;
  logic [2:0]  count_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_q[$];
  bit          m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_pc;

  fetch_queue dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .stall_in        (stall_in),
    .imem_addr_out   (imem_addr_out),
    .imem_req_out    (imem_req_out),
    .imem_data_in    (imem_data_in),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .pc_seq_out      (pc_seq_out),
    .valid_out       (valid_out),
    .count_out       (count_out)
  );

  always #5 clk = ~clk;

  // ROM word n holds the value n.
  always @(posedge clk) imem_data_in <= {22'd0, imem_addr_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_inf    = 1'b0;
    m_inf_pc = 32'd0;
    m_pc     = 32'd0;
  endtask

  task automatic chk_reset();
    chk("rst_valid",  32'(valid_out), 32'd0);
    chk("rst_inst",   instruction_out, NOP);
    chk("rst_pc",     pc_out, 32'd0);
    chk("rst_pc_seq", pc_seq_out, 32'd4);
    chk("rst_count",  32'(count_out), 32'd0);
    chk("rst_req",    32'(imem_req_out), 32'd0);
  endtask

  task automatic step(input bit rd, input logic [31:0] tgt, input bit st);
    bit          ev;
    bit          ereq;
    logic [31:0] hp;
    redirect_in    = rd;
    redirect_pc_in = tgt;
    stall_in       = st;
    #1;
    ev   = (m_q.size() != 0) && !rd;
    hp   = ev ? m_q[0] : 32'd0;
    ereq = !rd && ((m_q.size() + int'(m_inf)) < 4);
    chk("valid",  32'(valid_out), 32'(ev));
    chk("inst",   instruction_out, ev ? ((hp >> 2) & 32'h3FF) : NOP);
    chk("pc",     pc_out, hp);
    chk("pc_seq", pc_seq_out, hp + 32'd4);
    chk("count",  32'(count_out), 32'(m_q.size()));
    chk("req",    32'(imem_req_out), 32'(ereq));
    chk("addr",   32'(imem_addr_out), (m_pc >> 2) & 32'h3FF);
    @(posedge clk);
    if (rd) begin
      m_q.delete();
      m_inf = 1'b0;
      m_pc  = tgt & 32'hFFFF_FFFC;
    end else begin
      if (ev && !st) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_pc);
      m_inf = ereq;
      if (ereq) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b0;
    redirect_in    = 1'b0;
    redirect_pc_in = 32'd0;
    stall_in       = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk_reset();
    reset = 1'b1;

    repeat (12) step(1'b0, 32'd0, 1'b0);

    repeat (10) step(1'b0, 32'd0, 1'b1);
    repeat (8)  step(1'b0, 32'd0, 1'b0);

    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'h100, 1'b0);
    repeat (6) step(1'b0, 32'd0, 1'b0);

    step(1'b1, 32'h203, 1'b1);
    repeat (5) step(1'b0, 32'd0, 1'b0);

    step(1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (6) step(1'b0, 32'd0, 1'b0);

    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("count_before_reset", 32'(count_out), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk_reset();
    m_reset();
    @(negedge clk);
    chk_reset();
    reset = 1'b1;
    repeat (8) step(1'b0, 32'd0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
